// File: rtl/layer_weight_accumulator_pkg.sv
// Shared types and arithmetic helpers for the layer weight accumulator.
package layer_acc_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} acc_state_t;

  // Saturating add of two sign-extended operands; the result is clamped to
  // the signed range of a 'width'-bit accumulator (width must be <= 63).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 width);
    logic signed [63:0] s, hi, lo;
    s  = a + b;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/layer_weight_accumulator_acc_lane.sv
// One signed accumulator lane: clear, enable, sign-extend weight, add.
// Build option: ACC_SATURATE_EN clamps each add to the accumulator range;
// without it the add wraps modulo 2^acc_size.
module acc_lane #(
  parameter int w_size   = 8,
  parameter int acc_size = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic [w_size-1:0]   w,
  output logic [acc_size-1:0] acc
);

  logic signed [acc_size-1:0] ext;
  logic signed [acc_size-1:0] nxt;

  assign ext = acc_size'($signed(w));

`ifdef ACC_SATURATE_EN
  assign nxt = acc_size'(layer_acc_pkg::sat_add(64'($signed(acc)), 64'(ext), acc_size));
`else
  assign nxt = $signed(acc) + ext;
`endif

  // Accumulator register: clear wins over enable so a new run starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= nxt;
  end

endmodule

// File: rtl/layer_weight_accumulator.sv
// Reads the inter-layer weight ROM for every active input spike and sums the
// returned rows into one signed accumulator per output neuron.
// Build option: ACC_SATURATE_EN selects saturating accumulation (see acc_lane).
module layer_weight_accumulator
  import layer_acc_pkg::*;
#(
  parameter int w_size      = 8,
  parameter int neurons_in  = 8,
  parameter int neurons_out = 2,
  parameter int acc_size    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [neurons_in-1:0]           spikes_in,
  output logic [neurons_in-1:0]           rom_addr,
  input  logic [neurons_out*w_size-1:0]   rom_data,
  output logic                            busy,
  output logic                            done,
  output logic [neurons_out*acc_size-1:0] sums
);

  localparam int IW = (neurons_in > 1) ? $clog2(neurons_in) : 1;
  localparam logic [IW-1:0] LAST = IW'(neurons_in - 1);

  acc_state_t            state, state_nxt;
  logic [IW-1:0]         idx;
  logic [neurons_in-1:0] spk;
  logic                  accept, hit, acc_clr, acc_en;

  assign accept = (state == IDLE) && start;
  assign hit    = spk[idx];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and decoded outputs; the scan length is fixed at neurons_in.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rom_addr  = '0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc_clr   = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (hit) begin
          rom_addr = neurons_in'(1) << idx;
          acc_en   = 1'b1;
        end
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Scan index and spike snapshot; both restart only on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      spk <= '0;
    end else if (accept) begin
      idx <= '0;
      spk <= spikes_in;
    end else if (state == SCAN && idx != LAST) begin
      idx <= idx + IW'(1);
    end
  end

  for (genvar j = 0; j < neurons_out; j++) begin : g_lane
    acc_lane #(
      .w_size   (w_size),
      .acc_size (acc_size)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (acc_clr),
      .en    (acc_en),
      .w     (rom_data[j*w_size +: w_size]),
      .acc   (sums[j*acc_size +: acc_size])
    );
  end

endmodule
